// File: rtl/adr_pch_responder.sv
// PCH-side ADR responder: on a CPLD ADR trigger it emulates the cache flush,
// reports completion, waits for the CPLD acknowledge (or times out) and enters S3.
module adr_pch_responder #(
  parameter int FLUSH_CYCLES = 200,
  parameter int ACK_TIMEOUT  = 2000,
  parameter int SLP3_DELAY   = 10
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iEna,
  input  logic       iFmAdrTrigger_n,
  input  logic       iFmAdrAck_n,
  output logic       oFmAdrComplete,
  output logic       oFmSlp3_n,
  output logic       oAdrBusy,
  output logic       oAdrTimeout,
  output logic [7:0] oAdrEventCnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    FLUSH      = 3'd2,
    COMPLETE   = 3'd3,
    WAIT_ACK   = 3'd4,
    PWR_DN_DLY = 3'd5,
    S3         = 3'd6
  } state_t;

  // Terminal values of the shared counter; parameters stay within 1..4095,
  // so the counter stops at or below 4094 and can never wrap.
  localparam logic [11:0] FLUSH_LAST = 12'(FLUSH_CYCLES - 1);
  localparam logic [11:0] ACK_LAST   = 12'(ACK_TIMEOUT - 1);
  localparam logic [11:0] SLP3_LAST  = 12'(SLP3_DELAY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_cnt;
  logic [11:0] w_cnt_nxt;
  logic        r_trig_prev;
  logic        r_ack_prev;
  logic        r_complete;
  logic        w_complete_nxt;
  logic        r_slp3_n;
  logic        w_slp3_n_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;
  logic [7:0]  r_evt_cnt;
  logic [7:0]  w_evt_cnt_nxt;
  logic        w_trig_fall;
  logic        w_ack_fall;
  logic        w_abortable;

  assign w_trig_fall = ~iFmAdrTrigger_n & r_trig_prev;
  assign w_ack_fall  = ~iFmAdrAck_n & r_ack_prev;
  assign w_abortable = r_state inside {ARMED, FLUSH, COMPLETE, WAIT_ACK, PWR_DN_DLY};

  always_ff @(posedge iClk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values and the order of the statements below does not matter.
    if (!iRst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_trig_prev <= 1'b1;
      r_ack_prev  <= 1'b1;
      r_complete  <= 1'b0;
      r_slp3_n    <= 1'b1;
      r_timeout   <= 1'b0;
      r_evt_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_trig_prev <= iFmAdrTrigger_n;
      r_ack_prev  <= iFmAdrAck_n;
      r_complete  <= w_complete_nxt;
      r_slp3_n    <= w_slp3_n_nxt;
      r_timeout   <= w_timeout_nxt;
      r_evt_cnt   <= w_evt_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every next value gets a hold default first, so no path through the
    // case below leaves one unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_complete_nxt = r_complete;
    w_slp3_n_nxt   = r_slp3_n;
    w_timeout_nxt  = r_timeout;
    w_evt_cnt_nxt  = r_evt_cnt;

    // Losing enable mid-sequence drops straight back to IDLE; history is kept.
    if (w_abortable && !iEna) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_complete_nxt = 1'b0;
      w_slp3_n_nxt   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt      = '0;
          w_complete_nxt = 1'b0;
          w_slp3_n_nxt   = 1'b1;
          if (iEna) w_state_nxt = ARMED;
        end
        ARMED: begin
          if (w_trig_fall) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = '0;
            if (r_evt_cnt != 8'hFF) w_evt_cnt_nxt = r_evt_cnt + 8'd1;
          end
        end
        FLUSH: begin
          if (r_cnt == FLUSH_LAST) begin
            w_state_nxt    = COMPLETE;
            w_complete_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 12'd1;
          end
        end
        COMPLETE: begin
          w_state_nxt = WAIT_ACK;
          w_cnt_nxt   = '0;
        end
        WAIT_ACK: begin
          // An ack arriving on the timeout cycle still counts as a clean ack.
          if (w_ack_fall) begin
            w_state_nxt    = PWR_DN_DLY;
            w_complete_nxt = 1'b0;
            w_cnt_nxt      = '0;
          end else if (r_cnt == ACK_LAST) begin
            w_state_nxt    = PWR_DN_DLY;
            w_complete_nxt = 1'b0;
            w_timeout_nxt  = 1'b1;
            w_cnt_nxt      = '0;
          end else begin
            w_cnt_nxt = r_cnt + 12'd1;
          end
        end
        PWR_DN_DLY: begin
          if (r_cnt == SLP3_LAST) begin
            w_state_nxt  = S3;
            w_slp3_n_nxt = 1'b0;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + 12'd1;
          end
        end
        S3: begin
          w_slp3_n_nxt = 1'b0;
          if (!iEna) begin
            w_state_nxt  = IDLE;
            w_slp3_n_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_cnt_nxt      = '0;
          w_complete_nxt = 1'b0;
          w_slp3_n_nxt   = 1'b1;
        end
      endcase
    end
  end

  assign oFmAdrComplete = r_complete;
  assign oFmSlp3_n      = r_slp3_n;
  assign oAdrBusy       = r_state inside {FLUSH, COMPLETE, WAIT_ACK, PWR_DN_DLY};
  assign oAdrTimeout    = r_timeout;
  assign oAdrEventCnt   = r_evt_cnt;

endmodule

// File: tb/tb_adr_pch_responder.sv
// Scoreboard bench for adr_pch_responder: each scripted flow predicts its output
// changes by edge number; a negedge monitor pops and compares them as they occur.
module tb_adr_pch_responder;

  localparam int FLUSH      = 200;
  localparam int ACK_TO     = 2000;
  localparam int SLP3       = 10;
  localparam int MAX_CYCLES = 95000;

  logic       iClk            = 1'b0;
  logic       iRst_n          = 1'b0;
  logic       iEna            = 1'b0;
  logic       iFmAdrTrigger_n = 1'b1;
  logic       iFmAdrAck_n     = 1'b1;
  logic       oFmAdrComplete;
  logic       oFmSlp3_n;
  logic       oAdrBusy;
  logic       oAdrTimeout;
  logic [7:0] oAdrEventCnt;

  typedef struct packed {
    logic       complete;
    logic       slp3_n;
    logic       busy;
    logic       timeout;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    int   at;
    obs_t o;
  } ev_t;

  typedef struct {
    string name;
    obs_t  o;
  } dchk_t;

  // Externally visible phases of a flow; COMPLETE and WAIT_ACK look identical.
  typedef enum { P_IDLE, P_FLUSH, P_DONE, P_DLY, P_S3 } phase_t;

  ev_t   exp_q[$];
  dchk_t dir_q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  bit    mon_on = 1'b0;
  bit    drain_req = 1'b0;
  bit    drain_done = 1'b0;
  obs_t  mon_last;

  obs_t  m_last;
  int    m_events = 0;
  bit    m_timeout = 1'b0;

  adr_pch_responder dut (
    .iClk            (iClk),
    .iRst_n          (iRst_n),
    .iEna            (iEna),
    .iFmAdrTrigger_n (iFmAdrTrigger_n),
    .iFmAdrAck_n     (iFmAdrAck_n),
    .oFmAdrComplete  (oFmAdrComplete),
    .oFmSlp3_n       (oFmSlp3_n),
    .oAdrBusy        (oAdrBusy),
    .oAdrTimeout     (oAdrTimeout),
    .oAdrEventCnt    (oAdrEventCnt)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  function automatic obs_t mk(input logic c, input logic s, input logic b,
                              input logic t, input logic [7:0] n);
    obs_t r;
    r.complete = c;
    r.slp3_n   = s;
    r.busy     = b;
    r.timeout  = t;
    r.cnt      = n;
    return r;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("complete=%b slp3_n=%b busy=%b timeout=%b cnt=%0d",
                     o.complete, o.slp3_n, o.busy, o.timeout, o.cnt);
  endfunction

  function automatic obs_t phase_obs(input phase_t ph);
    logic [7:0] n;
    n = (m_events > 255) ? 8'd255 : 8'(m_events);
    return mk(ph == P_DONE, ph != P_S3, ph inside {P_FLUSH, P_DONE, P_DLY}, m_timeout, n);
  endfunction

  task automatic expect_ev(input int at, input phase_t ph);
    obs_t o;
    ev_t  e;
    o = phase_obs(ph);
    if (o != m_last) begin
      e.at = at;
      e.o  = o;
      exp_q.push_back(e);
      m_last = o;
    end
  endtask

  task automatic expect_now(input string name, input obs_t o);
    dchk_t d;
    d.name = name;
    d.o    = o;
    dir_q.push_back(d);
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %s, want %s", name, cyc, fmt(act), fmt(exp));
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // One ADR flow starting from IDLE. ack_j: WAIT_ACK cycle of the ack (0 = none).
  // cut_kind: 0 none, 1 drop enable, 2 reset, applied at edge detect+cut_off.
  task automatic run_flow(input int ack_j, input int cut_off, input int cut_kind,
                          input bit noisy, input int dwell);
    int a, d, w, p, s, e, x, fin;
    bit cut;
    a   = cyc + 1;
    d   = a + (noisy ? 2 : 1) + dwell;
    w   = d + FLUSH + 1;
    p   = (ack_j > 0) ? w + ack_j : w + ACK_TO;
    s   = p + SLP3;
    e   = s + 1 + dwell;
    cut = (cut_kind != 0);
    x   = d + cut_off;
    fin = cut ? x : e;

    m_events++;
    expect_ev(d, P_FLUSH);
    if (!cut || d + FLUSH < x) expect_ev(d + FLUSH, P_DONE);
    if (!cut || p < x) begin
      if (ack_j == 0) m_timeout = 1'b1;
      expect_ev(p, P_DLY);
    end
    if (!cut || s < x) expect_ev(s, P_S3);
    if (cut_kind == 2) begin
      m_events  = 0;
      m_timeout = 1'b0;
    end
    expect_ev(fin, P_IDLE);

    for (int n = a; n <= fin; n++) begin
      iEna            = (n < fin);
      iRst_n          = !(cut_kind == 2 && n == x);
      iFmAdrTrigger_n = 1'b1;
      iFmAdrAck_n     = 1'b1;
      if (n == d) iFmAdrTrigger_n = 1'b0;
      else if (noisy && n == a) iFmAdrTrigger_n = 1'b0;
      else if (noisy && n > d && n < fin && $urandom_range(0, 7) == 0) iFmAdrTrigger_n = 1'b0;
      if (ack_j > 0 && n == w + ack_j) iFmAdrAck_n = 1'b0;
      else if (noisy && n == a + 1) iFmAdrAck_n = 1'b0;
      else if (noisy && ((n > d && n <= d + FLUSH) || (n > p && n < fin)) &&
               $urandom_range(0, 7) == 0) iFmAdrAck_n = 1'b0;
      step();
    end
    iEna            = 1'b0;
    iRst_n          = 1'b1;
    iFmAdrTrigger_n = 1'b1;
    iFmAdrAck_n     = 1'b1;
  endtask

  always @(negedge iClk) begin
    obs_t  o;
    ev_t   ev;
    dchk_t dc;
    o = mk(oFmAdrComplete, oFmSlp3_n, oAdrBusy, oAdrTimeout, oAdrEventCnt);
    if (!mon_on) begin
      mon_last = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_event @edge %0d: got %s, want %s at edge %0d",
                 cyc, fmt(o), fmt(exp_q[0].o), exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (o !== mon_last) begin
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
          ev = exp_q.pop_front();
          check("event", o, ev.o);
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_change @edge %0d: got %s, want %s",
                   cyc, fmt(o), fmt(mon_last));
        end
        mon_last = o;
      end
      while (dir_q.size() > 0) begin
        dc = dir_q.pop_front();
        check(dc.name, o, dc.o);
      end
      if (drain_req && !drain_done) begin
        n_tests++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: got %0d pending events, want 0", exp_q.size());
        end
        drain_done = 1'b1;
      end
    end
  end

  initial begin
    repeat (MAX_CYCLES) @(posedge iClk);
    $display("FAIL watchdog: got %0d cycles without finishing, want fewer than %0d", cyc, MAX_CYCLES);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  j, off, kind, dw;
    bit  nz;
    m_last = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (3) step();
    mon_on = 1'b1;
    expect_now("reset_state", mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    iRst_n = 1'b1;
    step();

    run_flow(39, 0, 0, 1'b0, 0);
    expect_now("nominal", mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
    run_flow(0, 0, 0, 1'b0, 0);
    expect_now("ack_timeout", mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd2));
    run_flow(25, 0, 0, 1'b1, 1);
    expect_now("spurious_edges", mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd3));
    run_flow(30, FLUSH + 21, 2, 1'b1, 0);
    expect_now("reset_mid_wait", mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    run_flow(30, 100, 1, 1'b0, 0);
    expect_now("abort_flush", mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
    run_flow(10, 0, 0, 1'b0, 0);
    expect_now("reenable_flow", mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd2));
    run_flow(ACK_TO, 0, 0, 1'b0, 0);
    expect_now("ack_timeout_tie", mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd3));

    repeat (8) begin
      j    = int'($urandom_range(1, 40));
      nz   = ($urandom_range(0, 1) == 1);
      dw   = int'($urandom_range(0, 2));
      kind = 0;
      off  = 0;
      if ($urandom_range(0, 3) == 0) begin
        kind = int'($urandom_range(1, 2));
        off  = int'($urandom_range(1, FLUSH + j + SLP3));
      end
      run_flow(j, off, kind, nz, dw);
    end

    repeat (300) run_flow(1, 0, 0, 1'b0, 0);
    expect_now("saturation", mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd255));

    repeat (3) step();
    drain_req = 1'b1;
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adr_pch_responder.md
ADR_PCH_RESPONDER -- requirements
Module: adr_pch_responder

Interface
REQ-001 Parameter FLUSH_CYCLES, default 200, sets the cycles from trigger detect to oFmAdrComplete assertion (100 us at 2 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 2000, sets the maximum cycles in WAIT_ACK before the timeout path is taken.
REQ-003 Parameter SLP3_DELAY, default 10, sets the cycles from ack detect (or timeout) to oFmSlp3_n assertion.
REQ-004 iClk  in  1  block clock, 2 MHz.
REQ-005 iRst_n  in  1  reset; synchronous, active-low.
REQ-006 iEna  in  1  responder enable; level, from the master sequencer.
REQ-007 iFmAdrTrigger_n  in  1  ADR trigger from the CPLD ADR FSM; active-low pulse, may be 1 cycle wide.
REQ-008 iFmAdrAck_n  in  1  ADR acknowledge from the CPLD; active-low pulse, may be 1 cycle wide.
REQ-009 oFmAdrComplete  out  1  ADR flush complete; active-high level.
REQ-010 oFmSlp3_n  out  1  emulated SLP_S3#; low means S3 entered.
REQ-011 oAdrBusy  out  1  high in every state except IDLE, ARMED and S3.
REQ-012 oAdrTimeout  out  1  sticky flag; set when the ack timeout is taken.
REQ-013 oAdrEventCnt  out  8  count of trigger detects; saturates at 255.

Function
REQ-014 The block SHALL register iFmAdrTrigger_n and iFmAdrAck_n once (prev-value flops) and detect a falling edge as current==0 && prev==1.
REQ-015 FSM states SHALL be IDLE, ARMED, FLUSH, COMPLETE, WAIT_ACK, PWR_DN_DLY, S3, encoded in 3 bits.
REQ-016 IDLE: oFmSlp3_n=1, oFmAdrComplete=0; iEna=1 -> ARMED on the next edge.
REQ-017 ARMED: a trigger falling edge -> FLUSH, load the flush counter with 0, and increment oAdrEventCnt (saturating).
REQ-018 FLUSH: counter increments each cycle; when it reaches FLUSH_CYCLES-1 -> COMPLETE, and oFmAdrComplete is set on the same edge, so oFmAdrComplete is high exactly FLUSH_CYCLES edges after the detect edge.
REQ-019 COMPLETE: unconditional -> WAIT_ACK next cycle, clearing the counter; oFmAdrComplete stays high.
REQ-020 WAIT_ACK: an ack falling edge -> PWR_DN_DLY, oFmAdrComplete cleared on that edge, counter cleared.
REQ-021 WAIT_ACK: if the counter reaches ACK_TIMEOUT-1 without an ack -> PWR_DN_DLY, oFmAdrComplete cleared, oAdrTimeout set.
REQ-022 Ack edge and timeout on the same cycle: the ack wins and oAdrTimeout is not set.
REQ-023 PWR_DN_DLY: after SLP3_DELAY cycles -> S3, with oFmSlp3_n driven 0 on that edge.
REQ-024 S3: oFmSlp3_n held 0; iEna=0 -> IDLE, with oFmSlp3_n=1 on that edge.
REQ-025 Trigger edges outside ARMED, and ack edges outside WAIT_ACK, SHALL be ignored and SHALL NOT change the count.
REQ-026 iEna=0 in ARMED, FLUSH, COMPLETE, WAIT_ACK or PWR_DN_DLY SHALL abort to IDLE on the next edge: oFmAdrComplete=0, oFmSlp3_n=1, counter cleared, oAdrEventCnt and oAdrTimeout kept.
REQ-027 A trigger edge on the same cycle as the IDLE->ARMED transition SHALL be ignored.
REQ-028 The shared 12-bit counter SHALL NOT wrap; parameters SHALL be in the range 1..4095.

Reset
REQ-029 iRst_n=0 sampled at an edge SHALL force IDLE, oFmAdrComplete=0, oFmSlp3_n=1, oAdrBusy=0, oAdrTimeout=0, oAdrEventCnt=0, counter=0, edge-detect prev flops=1, in any state including mid-flush.
REQ-030 The first transition after reset release SHALL occur on the first edge with iRst_n=1.

Verification
REQ-031 Nominal: iEna=1, 1-cycle trigger low -> oFmAdrComplete high 200 cycles later; ack pulse 40 cycles later -> complete low on the same edge, oFmSlp3_n low 10 cycles later, oAdrEventCnt=1, oAdrTimeout=0.
REQ-032 Timeout: trigger, no ack -> oFmAdrComplete low after 2000 cycles in WAIT_ACK, oAdrTimeout=1, oFmSlp3_n low 10 cycles later.
REQ-033 Spurious: ack pulse in ARMED and trigger pulse in FLUSH -> no state change, oAdrEventCnt unchanged.
REQ-034 Abort: iEna=0 at flush cycle 100 -> IDLE next edge, complete=0, slp3_n=1; re-enable and re-trigger -> full flow, oAdrEventCnt=2.
REQ-035 Reset mid-WAIT_ACK -> all outputs at reset values next edge, oAdrTimeout=0, oAdrEventCnt=0.
REQ-036 Saturation: 300 triggers, each with an ack and an S3 exit -> oAdrEventCnt=255.
